// File: rtl/ifetch_prefetch.sv
// Instruction fetch stage: issues iBus requests under a credit limit, buffers
// in-order responses in a prefetch FIFO and drops stale responses after a redirect.
module ifetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rstf,
  output logic        iBus_cmd_valid,
  input  logic        iBus_cmd_ready,
  output logic [31:0] iBus_cmd_payload_pc,
  input  logic        iBus_rsp_ready,
  input  logic        iBus_rsp_err,
  input  logic [31:0] iBus_rsp_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  logic          started;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [PW-1:0] pc_wr;
  logic [PW-1:0] pc_rd;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   pc_q   [DEPTH];
  entry_t        data_q [DEPTH];

  logic          cmd_fire;
  logic          rsp_fire;
  logic          pop;
  logic          push;
  logic [CW-1:0] inflight_nxt;
  logic [CW:0]   credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit covers stale requests too, so the FIFO can never overflow.
  assign credit_used         = {1'b0, inflight} + {1'b0, count};
  assign iBus_cmd_valid      = started && (credit_used < (CW + 1)'(DEPTH));
  assign iBus_cmd_payload_pc = fetch_pc;

  assign cmd_fire     = iBus_cmd_valid & iBus_cmd_ready;
  assign rsp_fire     = iBus_rsp_ready && (inflight != '0);
  assign pop          = out_valid & out_ready;
  assign push         = rsp_fire && (drop == '0) && !redirect_valid;
  assign inflight_nxt = inflight + CW'(cmd_fire) - CW'(rsp_fire);

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? data_q[rd_ptr].pc    : '0;
  assign out_instr = out_valid ? data_q[rd_ptr].instr : '0;
  assign out_err   = out_valid ? data_q[rd_ptr].err   : 1'b0;

  // NOTE: storage arrays carry no reset; pointers and counters alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (cmd_fire) pc_q[pc_wr] <= fetch_pc;
    if (push)     data_q[wr_ptr] <= entry_t'{pc: pc_q[pc_rd], instr: iBus_rsp_instr, err: iBus_rsp_err};
  end

  // NOTE: every register uses <= so all updates below see pre-edge values regardless of order.
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      started  <= 1'b0;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      count    <= '0;
      pc_wr    <= '0;
      pc_rd    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      started  <= 1'b1;
      inflight <= inflight_nxt;
      if (cmd_fire) pc_wr  <= ptr_inc(pc_wr);
      if (rsp_fire) pc_rd  <= ptr_inc(pc_rd);
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old stream.
        fetch_pc <= redirect_pc & ~32'd3;
        drop     <= inflight_nxt;
        count    <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        if (cmd_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_fire && (drop != '0)) drop <= drop - 1'b1;
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: a bus/memory responder plus a queue-based
// reference of issued requests and deliverable instructions, compared every cycle.
module tb_ifetch_prefetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstf;
  logic        iBus_cmd_valid;
  logic        iBus_cmd_ready;
  logic [31:0] iBus_cmd_payload_pc;
  logic        iBus_rsp_ready;
  logic        iBus_rsp_err;
  logic [31:0] iBus_rsp_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_err;

  ifetch_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rstf                (rstf),
    .iBus_cmd_valid      (iBus_cmd_valid),
    .iBus_cmd_ready      (iBus_cmd_ready),
    .iBus_cmd_payload_pc (iBus_cmd_payload_pc),
    .iBus_rsp_ready      (iBus_rsp_ready),
    .iBus_rsp_err        (iBus_rsp_err),
    .iBus_rsp_instr      (iBus_rsp_instr),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_pc              (out_pc),
    .out_instr           (out_instr),
    .out_err             (out_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } ent_t;
  typedef struct { logic [31:0] pc; logic stale; } req_t;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference state: requests on the bus and instructions the core may still see.
  req_t        bus_q[$];
  ent_t        exp_q[$];
  logic [31:0] m_fetch_pc;
  bit          m_started;

  // Stimulus knobs (percent probabilities) and directed overrides.
  int          p_cmd, p_rsp, p_out, p_redir, p_err, p_spur;
  bit          force_redir;
  logic [31:0] force_pc;
  logic [31:0] err_pc;

  // Observation logs for the directed literal checks.
  logic [31:0] cmd_log[$];
  ent_t        pop_log[$];
  int          t_first_fire, t_first_out;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    cmd_log.delete();
    pop_log.delete();
    t_first_fire = -1;
    t_first_out  = -1;
  endtask

  task automatic set_knobs(input int c, input int r, input int o);
    p_cmd = c; p_rsp = r; p_out = o;
    p_redir = 0; p_err = 0; p_spur = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstf           = 1'b0;
    iBus_cmd_ready = 1'b0;
    iBus_rsp_ready = 1'b0;
    iBus_rsp_err   = 1'b0;
    iBus_rsp_instr = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    force_redir    = 1'b0;
    err_pc         = 32'h1;
    bus_q.delete();
    exp_q.delete();
    m_fetch_pc = RESET_PC;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_err", out_err, 0);
    check("rst_cmd_valid", iBus_cmd_valid, 0);
    check("rst_cmd_pc", iBus_cmd_payload_pc, RESET_PC);
    rstf = 1'b1;
    // The edge after release only arms fetch; all inputs are idle on it.
    m_started = 1'b1;
    clear_logs();
  endtask

  // One cycle: compare outputs against the reference, drive inputs, advance the reference.
  task automatic step();
    bit   exp_cv, fire, pop;
    req_t r;
    @(negedge clk);
    cyc++;
    exp_cv = m_started && ((bus_q.size() + exp_q.size()) < DEPTH);
    check("cmd_valid", iBus_cmd_valid, exp_cv);
    if (exp_cv) check("cmd_pc", iBus_cmd_payload_pc, m_fetch_pc);
    check("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("out_pc", out_pc, exp_q[0].pc);
      check("out_instr", out_instr, exp_q[0].instr);
      check("out_err", out_err, exp_q[0].err);
    end

    iBus_cmd_ready = ($urandom_range(99) < p_cmd);
    out_ready      = ($urandom_range(99) < p_out);
    redirect_valid = force_redir || ($urandom_range(99) < p_redir);
    redirect_pc    = force_redir ? force_pc : $urandom;
    if (bus_q.size() != 0) begin
      iBus_rsp_ready = ($urandom_range(99) < p_rsp);
      iBus_rsp_instr = mem_word(bus_q[0].pc);
      iBus_rsp_err   = (bus_q[0].pc == err_pc) || ($urandom_range(99) < p_err);
    end else begin
      iBus_rsp_ready = ($urandom_range(99) < p_spur);
      iBus_rsp_instr = $urandom;
      iBus_rsp_err   = $urandom_range(1);
    end

    if (iBus_cmd_valid && iBus_cmd_ready) begin
      cmd_log.push_back(iBus_cmd_payload_pc);
      if (t_first_fire < 0) t_first_fire = cyc;
    end
    if (out_valid && t_first_out < 0) t_first_out = cyc;
    if (out_valid && out_ready) pop_log.push_back('{out_pc, out_instr, out_err});

    fire = exp_cv && iBus_cmd_ready;
    pop  = (exp_q.size() != 0) && out_ready;
    if (pop) void'(exp_q.pop_front());
    if (iBus_rsp_ready && bus_q.size() != 0) begin
      r = bus_q.pop_front();
      if (!r.stale && !redirect_valid)
        exp_q.push_back('{r.pc, iBus_rsp_instr, iBus_rsp_err});
    end
    if (fire) bus_q.push_back('{m_fetch_pc, 1'b0});
    if (redirect_valid) begin
      exp_q.delete();
      foreach (bus_q[i]) bus_q[i].stale = 1'b1;
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
    end else if (fire) begin
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int bad;
    rstf = 1'b0;

    // Streaming from RESET_PC with 1-cycle responses.
    do_reset();
    set_knobs(100, 100, 100);
    run(12);
    check("t1_pop0", pop_log[0].pc, 32'h100);
    check("t1_pop1", pop_log[1].pc, 32'h104);
    check("t1_pop2", pop_log[2].pc, 32'h108);
    check("t1_latency", t_first_out - t_first_fire, 2);
    check("t1_pops", pop_log.size(), 10);

    // Backpressure from decode fills the credit window.
    do_reset();
    set_knobs(100, 100, 0);
    run(10);
    check("t2_fires", cmd_log.size(), 4);
    check("t2_cmd_valid_off", iBus_cmd_valid, 0);
    clear_logs();
    p_out = 100;
    run(8);
    check("t2_pop0", pop_log[0].pc, 32'h100);
    check("t2_pop1", pop_log[1].pc, 32'h104);
    check("t2_pop2", pop_log[2].pc, 32'h108);
    check("t2_pop3", pop_log[3].pc, 32'h10c);
    check("t2_resume", cmd_log[0], 32'h110);

    // Bus stall holds the request stable.
    do_reset();
    set_knobs(0, 100, 100);
    run(5);
    check("t3_cmd_valid", iBus_cmd_valid, 1);
    check("t3_cmd_pc", iBus_cmd_payload_pc, 32'h100);
    check("t3_out_valid", out_valid, 0);
    check("t3_no_fire", cmd_log.size(), 0);

    // Redirect with three requests outstanding.
    do_reset();
    set_knobs(100, 0, 100);
    for (int i = 0; i < 20 && cmd_log.size() < 3; i++) step();
    check("t4_fires", cmd_log.size(), 3);
    p_cmd = 0;
    force_redir = 1'b1;
    force_pc    = 32'h203;
    step();
    force_redir = 1'b0;
    set_knobs(100, 100, 100);
    run(15);
    check("t4_first_pc", pop_log[0].pc, 32'h200);
    check("t4_first_instr", pop_log[0].instr, mem_word(32'h200));
    bad = 0;
    foreach (pop_log[i]) if (pop_log[i].pc < 32'h200) bad++;
    check("t4_stale_seen", bad, 0);

    // Redirect coinciding with a cmd_fire, a rsp_fire and a pop.
    do_reset();
    set_knobs(100, 100, 100);
    run(6);
    clear_logs();
    check("t5_cmd_busy", iBus_cmd_valid, 1);
    force_redir = 1'b1;
    force_pc    = 32'h300;
    step();
    force_redir = 1'b0;
    run(10);
    check("t5_same_cycle_pop", pop_log[0].pc, 32'h110);
    check("t5_next_pc", pop_log[1].pc, 32'h300);
    check("t5_next2_pc", pop_log[2].pc, 32'h304);

    // Bus error on a single response.
    do_reset();
    set_knobs(100, 100, 100);
    err_pc = 32'h104;
    run(8);
    check("t6_err0", pop_log[0].err, 0);
    check("t6_err1", pop_log[1].err, 1);
    check("t6_err1_pc", pop_log[1].pc, 32'h104);
    check("t6_err2", pop_log[2].err, 0);
    check("t6_cont", pop_log[3].pc, 32'h10c);

    // Randomised traffic, including spurious responses and random redirects.
    for (int seg = 0; seg < 40; seg++) begin
      if (seg % 10 == 0) do_reset();
      p_cmd   = $urandom_range(100, 10);
      p_rsp   = $urandom_range(100, 10);
      p_out   = $urandom_range(100, 10);
      p_redir = $urandom_range(8);
      p_err   = $urandom_range(15);
      p_spur  = $urandom_range(30);
      run(100);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
